// File: rtl/store_narrow_unit_pkg.sv
// Shared MIPS opcode constants and the store-buffer entry layout used by the
// store path (also consumed by the control unit and sign_extend).
package store_narrow_unit_pkg;

   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LW    = 6'b100011;

   localparam int ENTRY_W = 30 + 32 + 4;

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } store_entry_t;

endpackage

// File: rtl/store_narrow_unit_fifo.sv
// Generic synchronous FIFO (module store_fifo): control state is reset,
// storage is not; dout shows the head entry.
module store_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && (count != CNT_W'(DEPTH));

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/store_narrow_unit.sv
// Store-path narrowing: sb/sh/sw lane decode and alignment check feeding a
// small FIFO toward the data-memory write port.
module store_narrow_unit
   import store_narrow_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      st_valid,
   output logic                      st_ready,
   input  logic [5:0]                st_opcode,
   input  logic [31:0]               st_addr,
   input  logic [31:0]               st_data,
   output logic                      mem_valid,
   input  logic                      mem_ready,
   output logic [31:0]               mem_addr,
   output logic [31:0]               mem_wdata,
   output logic [3:0]                mem_be,
   output logic                      misalign,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             accept;
   logic             is_store;
   logic             aligned;
   logic             push;
   logic             pop;
   store_entry_t     entry_in;
   store_entry_t     entry_out;
   logic [ENTRY_W-1:0] fifo_dout;

   assign accept = st_valid && st_ready;

   always_comb begin
      entry_in       = '0;
      entry_in.waddr = st_addr[31:2];
      is_store       = 1'b0;
      aligned        = 1'b1;
      case (st_opcode)
         OP_SB: begin
            is_store       = 1'b1;
            entry_in.be    = 4'b0001 << st_addr[1:0];
            entry_in.wdata = {4{st_data[7:0]}};
         end
         OP_SH: begin
            is_store       = 1'b1;
            aligned        = !st_addr[0];
            entry_in.be    = st_addr[1] ? 4'b1100 : 4'b0011;
            entry_in.wdata = {2{st_data[15:0]}};
         end
         OP_SW: begin
            is_store       = 1'b1;
            aligned        = (st_addr[1:0] == 2'b00);
            entry_in.be    = 4'b1111;
            entry_in.wdata = st_data;
         end
         default: ;
      endcase
   end

   assign push = accept && is_store && aligned;
   assign pop  = mem_valid && mem_ready;

   store_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (entry_in),
      .dout  (fifo_dout),
      .count (count)
   );

   // Dropped misaligned stores flag one cycle later; non-stores never do.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign <= 1'b0;
      else        misalign <= accept && is_store && !aligned;
   end

   assign st_ready  = (count < CNT_W'(DEPTH));
   assign mem_valid = (count != '0);
   assign entry_out = fifo_dout;

   // Gating with mem_valid keeps unreset storage from reaching the port.
   assign mem_addr  = mem_valid ? {entry_out.waddr, 2'b00} : '0;
   assign mem_wdata = mem_valid ? entry_out.wdata : '0;
   assign mem_be    = mem_valid ? entry_out.be : '0;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed steps plus random traffic checked
// against a queue-based model of the store buffer.
module tb_store_narrow_unit;
   import store_narrow_unit_pkg::*;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        st_valid;
   logic        st_ready;
   logic [5:0]  st_opcode;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        misalign;
   logic [$clog2(DEPTH):0] count;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   exp_t q[$];
   logic mis_exp;
   int   nvec;
   int   nerr;

   store_narrow_unit #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_opcode (st_opcode),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .misalign  (misalign),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference behaviour written from the store rules with plain arithmetic.
   function automatic bit model_decode(input logic [5:0] op, input logic [31:0] a,
                                       input logic [31:0] d, output exp_t e, output bit mis);
      int lane;
      lane   = int'(a % 4);
      e.addr = a - 32'(lane);
      e.wdata = '0;
      e.be    = '0;
      mis     = 1'b0;
      if (op == OP_SB) begin
         e.be    = 4'(1 << lane);
         e.wdata = {24'b0, d[7:0]} * 32'h01010101;
         return 1'b1;
      end else if (op == OP_SH) begin
         mis     = (a % 2) != 0;
         e.be    = (lane == 2) ? 4'hC : 4'h3;
         e.wdata = {16'b0, d[15:0]} * 32'h00010001;
         return 1'b1;
      end else if (op == OP_SW) begin
         mis     = lane != 0;
         e.be    = 4'hF;
         e.wdata = d;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic check_outputs();
      chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
      chk("count", 32'(count), 32'(q.size()));
      chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
      chk("misalign", 32'(misalign), 32'(mis_exp));
      if (q.size() != 0) begin
         chk("mem_addr", mem_addr, q[0].addr);
         chk("mem_wdata", mem_wdata, q[0].wdata);
         chk("mem_be", 32'(mem_be), 32'(q[0].be));
      end else begin
         chk("mem_addr_idle", mem_addr, 32'h0);
         chk("mem_wdata_idle", mem_wdata, 32'h0);
         chk("mem_be_idle", 32'(mem_be), 32'h0);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input logic v, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic mr);
      exp_t e;
      bit   mis;
      bit   is_st;
      bit   acc;
      bit   pp;
      check_outputs();
      st_valid  = v;
      st_opcode = op;
      st_addr   = a;
      st_data   = d;
      mem_ready = mr;
      is_st = model_decode(op, a, d, e, mis);
      acc   = v && (q.size() < DEPTH);
      pp    = mr && (q.size() != 0);
      @(posedge clk);
      if (pp) void'(q.pop_front());
      if (acc && is_st && !mis) q.push_back(e);
      mis_exp = acc && is_st && mis;
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] ops [6];
      nvec = 0;
      nerr = 0;
      mis_exp = 1'b0;
      ops[0] = OP_SB; ops[1] = OP_SH; ops[2] = OP_SW;
      ops[3] = OP_ADDIU; ops[4] = OP_LW; ops[5] = OP_SW;
      rst_n = 1'b0;
      st_valid = 1'b0; st_opcode = '0; st_addr = '0; st_data = '0; mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // Lane decode
      cycle(1'b1, OP_SB, 32'h1003, 32'hAABBCCDD, 1'b1);
      chk("sb_addr", mem_addr, 32'h1000);
      chk("sb_be", 32'(mem_be), 32'h8);
      chk("sb_wdata", mem_wdata, 32'hDDDDDDDD);
      cycle(1'b0, OP_SB, 32'h0, 32'h0, 1'b1);
      cycle(1'b1, OP_SH, 32'h2002, 32'h12345678, 1'b1);
      chk("sh_be", 32'(mem_be), 32'hC);
      chk("sh_wdata", mem_wdata, 32'h56785678);
      cycle(1'b1, OP_SW, 32'h3000, 32'hCAFEF00D, 1'b1);
      chk("sw_be", 32'(mem_be), 32'hF);
      chk("sw_wdata", mem_wdata, 32'hCAFEF00D);
      cycle(1'b0, OP_SB, 32'h0, 32'h0, 1'b1);

      // Misaligned and non-store requests
      cycle(1'b1, OP_SW, 32'h3001, 32'h11111111, 1'b1);
      chk("mis_sw", 32'(misalign), 32'h1);
      cycle(1'b1, OP_SH, 32'h2003, 32'h22222222, 1'b1);
      chk("mis_sh", 32'(misalign), 32'h1);
      chk("mis_count", 32'(count), 32'h0);
      cycle(1'b1, OP_ADDIU, 32'h4000, 32'h33333333, 1'b1);
      chk("addiu_mis", 32'(misalign), 32'h0);
      chk("addiu_valid", 32'(mem_valid), 32'h0);
      cycle(1'b0, OP_SB, 32'h0, 32'h0, 1'b1);

      // Backpressure
      cycle(1'b1, OP_SW, 32'h100, 32'hA0A0A0A0, 1'b0);
      cycle(1'b1, OP_SW, 32'h104, 32'hB1B1B1B1, 1'b0);
      cycle(1'b1, OP_SW, 32'h108, 32'hC2C2C2C2, 1'b0);
      chk("full_ready", 32'(st_ready), 32'h0);
      chk("full_count", 32'(count), 32'h2);
      cycle(1'b1, OP_SW, 32'h108, 32'hC2C2C2C2, 1'b1);
      chk("pop_ready", 32'(st_ready), 32'h1);
      cycle(1'b1, OP_SW, 32'h108, 32'hC2C2C2C2, 1'b1);
      chk("third_count", 32'(count), 32'h1);
      cycle(1'b0, OP_SB, 32'h0, 32'h0, 1'b1);
      cycle(1'b0, OP_SB, 32'h0, 32'h0, 1'b1);

      // Simultaneous push/pop across pointer wrap
      cycle(1'b1, OP_SB, 32'h501, 32'h000000EE, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, OP_SW, {$urandom} & 32'hFFFFFFFC, $urandom, 1'b1);
         chk("wrap_count", 32'(count), 32'h1);
      end
      cycle(1'b0, OP_SB, 32'h0, 32'h0, 1'b1);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom % 10) < 7, ops[$urandom % 6], $urandom, $urandom,
               ($urandom % 10) < 6);
      end
      cycle(1'b0, OP_SB, 32'h0, 32'h0, 1'b1);
      cycle(1'b0, OP_SB, 32'h0, 32'h0, 1'b1);

      // Reset in the middle of a cycle with two entries buffered
      cycle(1'b1, OP_SW, 32'h200, 32'h12121212, 1'b0);
      cycle(1'b1, OP_SW, 32'h204, 32'h34343434, 1'b0);
      chk("pre_rst_count", 32'(count), 32'h2);
      st_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(mem_valid), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_mis", 32'(misalign), 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      q.delete();
      mis_exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, OP_SB, 32'h44, 32'h00000011, 1'b1);
      chk("post_rst_valid", 32'(mem_valid), 32'h1);
      chk("post_rst_be", 32'(mem_be), 32'h1);
      cycle(1'b0, OP_SB, 32'h0, 32'h0, 1'b1);
      check_outputs();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
